// File: rtl/wb_bus_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone bus arbiter:
// arbiter state encoding, bus widths and the round-robin tie-break helper.
package wb_bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    // Value held in the last_grant register for each master
    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;

    // The state register is the only source of the grant
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M0 = 2'd1,
        OWN_M1 = 2'd2
    } arb_state_t;

    // When both masters request together, the one not granted last wins
    function automatic arb_state_t tie_winner(input logic last_grant);
        return (last_grant == GRANT_M1) ? OWN_M0 : OWN_M1;
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Signal bundle around the arbiter: both master ports and the shared slave
// port. The slave modport is the arbiter's own view (it is the slave of the
// two masters); the master modport is the view of the surrounding system.
interface wb_bus_arbiter_if;
    import wb_bus_arbiter_pkg::*;

    // master 0 (instruction fetch)
    logic              m0_cyc_i;
    logic              m0_stb_i;
    logic              m0_we_i;
    logic [SEL_W-1:0]  m0_sel_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_data_i;
    logic [DATA_W-1:0] m0_data_o;
    logic              m0_ack_o;
    logic              m0_err_o;

    // master 1 (data)
    logic              m1_cyc_i;
    logic              m1_stb_i;
    logic              m1_we_i;
    logic [SEL_W-1:0]  m1_sel_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_data_i;
    logic [DATA_W-1:0] m1_data_o;
    logic              m1_ack_o;
    logic              m1_err_o;

    // shared slave
    logic              s_cyc_o;
    logic              s_stb_o;
    logic              s_we_o;
    logic [SEL_W-1:0]  s_sel_o;
    logic [ADDR_W-1:0] s_addr_o;
    logic [DATA_W-1:0] s_data_o;
    logic [DATA_W-1:0] s_data_i;
    logic              s_ack_i;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_addr_i, m0_data_i,
        output m0_data_o, m0_ack_o, m0_err_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_addr_i, m1_data_i,
        output m1_data_o, m1_ack_o, m1_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
        input  s_data_i, s_ack_i
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_addr_i, m0_data_i,
        input  m0_data_o, m0_ack_o, m0_err_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_addr_i, m1_data_i,
        input  m1_data_o, m1_ack_o, m1_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
        output s_data_i, s_ack_i
    );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog for the bus arbiter. Only present when WB_ARB_TIMEOUT_EN is
// defined; without the macro the arbiter has no counter and this file is empty.
// It counts consecutive strobe cycles the slave leaves un-acked and flags the
// cycle in which the count reaches TIMEOUT_CYCLES.
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic clear,
    output logic timeout
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    // The stalled cycle that would make the count reach TIMEOUT_CYCLES
    assign timeout = stall && (count == LIMIT);

    // Count stalled strobe cycles; restart on ack, owner change or abort
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 16'd0;
        end else if (clear || timeout) begin
            count <= 16'd0;
        end else if (stall) begin
            count <= count + 16'd1;
        end
    end

endmodule
`endif

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone bus arbiter (m0 instruction fetch, m1 data) in front of
// a single slave. Round-robin on simultaneous requests, ownership held for
// as long as the owner keeps cyc high, and one idle cycle between owners.
// Optional watchdog abort of stalled transfers: define WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    wb_bus_arbiter_if.slave    bus
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_bus_arbiter: TIMEOUT_CYCLES must lie in 2..65535");
    end

    arb_state_t state;
    arb_state_t state_next;
    logic       last_grant;
    logic       timeout;

`ifdef WB_ARB_TIMEOUT_EN
    logic stall_cycle;
    logic wd_clear;

    assign stall_cycle = (state != IDLE) && bus.s_stb_o && !bus.s_ack_i;
    assign wd_clear    = bus.s_ack_i || (state_next != state);

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall_cycle),
        .clear   (wd_clear),
        .timeout (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Next owner: grant from IDLE, release when the owner drops cyc or stalls out
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    state_next = tie_winner(last_grant);
                end else if (bus.m0_cyc_i) begin
                    state_next = OWN_M0;
                end else if (bus.m1_cyc_i) begin
                    state_next = OWN_M1;
                end
            end
            OWN_M0: begin
                if (!bus.m0_cyc_i || timeout) begin
                    state_next = IDLE;
                end
            end
            OWN_M1: begin
                if (!bus.m1_cyc_i || timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and round-robin memory of the most recent grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_M1;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next != IDLE) begin
                last_grant <= (state_next == OWN_M1) ? GRANT_M1 : GRANT_M0;
            end
        end
    end

    // Route the owner onto the slave port; strobe is gated by cyc so a master
    // that drops cyc with stb still high is cut off in that same cycle
    always_comb begin
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_we_o   = 1'b0;
        bus.s_sel_o  = '0;
        bus.s_addr_o = '0;
        bus.s_data_o = '0;
        unique case (state)
            OWN_M0: begin
                bus.s_cyc_o  = bus.m0_cyc_i;
                bus.s_stb_o  = bus.m0_cyc_i && bus.m0_stb_i;
                bus.s_we_o   = bus.m0_we_i;
                bus.s_sel_o  = bus.m0_sel_i;
                bus.s_addr_o = bus.m0_addr_i;
                bus.s_data_o = bus.m0_data_i;
            end
            OWN_M1: begin
                bus.s_cyc_o  = bus.m1_cyc_i;
                bus.s_stb_o  = bus.m1_cyc_i && bus.m1_stb_i;
                bus.s_we_o   = bus.m1_we_i;
                bus.s_sel_o  = bus.m1_sel_i;
                bus.s_addr_o = bus.m1_addr_i;
                bus.s_data_o = bus.m1_data_i;
            end
            default: ;
        endcase
    end

    // Return ack/err only to the owner; late acks after cyc drops are dropped
    always_comb begin
        bus.m0_ack_o = 1'b0;
        bus.m0_err_o = 1'b0;
        bus.m1_ack_o = 1'b0;
        bus.m1_err_o = 1'b0;
        if (state == OWN_M0) begin
            bus.m0_ack_o = bus.s_ack_i && bus.m0_cyc_i && bus.m0_stb_i;
            bus.m0_err_o = timeout;
        end
        if (state == OWN_M1) begin
            bus.m1_ack_o = bus.s_ack_i && bus.m1_cyc_i && bus.m1_stb_i;
            bus.m1_err_o = timeout;
        end
    end

    assign bus.m0_data_o = bus.s_data_i;
    assign bus.m1_data_o = bus.s_data_i;

endmodule
